// File: rtl/ov5640_cfg_seq_if.sv
// SCCB transaction handshake between the OV5640 configuration sequencer (master)
// and the SCCB bus engine (slave).
interface ov5640_cfg_seq_if;
    logic        sccb_req;
    logic        sccb_wr;
    logic [15:0] sccb_addr;
    logic [7:0]  sccb_wdata;
    logic        sccb_ack;
    logic        sccb_err;
    logic [7:0]  sccb_rdata;

    modport master (
        output sccb_req, sccb_wr, sccb_addr, sccb_wdata,
        input  sccb_ack, sccb_err, sccb_rdata
    );

    modport slave (
        input  sccb_req, sccb_wr, sccb_addr, sccb_wdata,
        output sccb_ack, sccb_err, sccb_rdata
    );
endinterface

// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-table configuration sequencer: writes REG_NUM ROM entries over SCCB with retries.
// Optional write-then-readback verification is enabled by defining CFG_READBACK_EN.
module ov5640_cfg_seq #(
    parameter logic [7:0]  REG_NUM   = 8'd250,
    parameter int unsigned PWR_DLY   = 20000,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    start,
    output logic [7:0]              rom_addr,
    input  logic [23:0]             rom_data,
    ov5640_cfg_seq_if.master        sccb,
    output logic                    busy,
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic [7:0]              err_idx,
    output logic [7:0]              rd_data
);
    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, FETCH, ISSUE, WAIT_ACK, VERIFY, NEXT, DONE, ERROR
    } state_t;

    localparam logic [31:0] DLY_LOAD  = (PWR_DLY > 32'd0) ? PWR_DLY - 32'd1 : 32'd0;
    localparam logic [2:0]  RETRY_LIM = RETRY_MAX[2:0];
    localparam logic [7:0]  LAST_IDX  = REG_NUM - 8'd1;

    state_t      state_reg, state_next;
    logic [31:0] dly_reg, dly_next;
    logic [7:0]  idx_reg, idx_next;
    logic [2:0]  attempt_reg, attempt_next;
    logic [7:0]  rom_addr_reg, rom_addr_next;
    logic        req_reg, req_next;
    logic        wr_reg, wr_next;
    logic [15:0] addr_reg, addr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic [7:0]  err_idx_reg, err_idx_next;
    logic [7:0]  rd_data_reg, rd_data_next;
    logic        attempt_fail;
`ifdef CFG_READBACK_EN
    logic        rd_issued_reg, rd_issued_next;
`else
    logic        unused_rdata;
    assign unused_rdata = ^sccb.sccb_rdata;
`endif

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_reg     <= IDLE;
            dly_reg       <= '0;
            idx_reg       <= '0;
            attempt_reg   <= '0;
            rom_addr_reg  <= '0;
            req_reg       <= 1'b0;
            wr_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_idx_reg   <= '0;
            rd_data_reg   <= '0;
`ifdef CFG_READBACK_EN
            rd_issued_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            dly_reg       <= dly_next;
            idx_reg       <= idx_next;
            attempt_reg   <= attempt_next;
            rom_addr_reg  <= rom_addr_next;
            req_reg       <= req_next;
            wr_reg        <= wr_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            err_idx_reg   <= err_idx_next;
            rd_data_reg   <= rd_data_next;
`ifdef CFG_READBACK_EN
            rd_issued_reg <= rd_issued_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        dly_next       = dly_reg;
        idx_next       = idx_reg;
        attempt_next   = attempt_reg;
        rom_addr_next  = rom_addr_reg;
        req_next       = req_reg;
        wr_next        = wr_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        done_next      = done_reg;
        err_next       = err_reg;
        err_idx_next   = err_idx_reg;
        rd_data_next   = rd_data_reg;
        attempt_fail   = 1'b0;
`ifdef CFG_READBACK_EN
        rd_issued_next = rd_issued_reg;
`endif
        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    done_next    = 1'b0;
                    err_next     = 1'b0;
                    err_idx_next = '0;
                    idx_next     = '0;
                    attempt_next = '0;
                    dly_next     = DLY_LOAD;
                    state_next   = PWR_WAIT;
                end
            end
            PWR_WAIT: begin
                // rom_addr moves on entry to FETCH so rom_data is valid in ISSUE.
                if (dly_reg == 32'd0) begin
                    rom_addr_next = idx_reg;
                    state_next    = FETCH;
                end else begin
                    dly_next = dly_reg - 32'd1;
                end
            end
            FETCH: state_next = ISSUE;
            ISSUE: begin
                addr_next  = rom_data[23:8];
                wdata_next = rom_data[7:0];
                wr_next    = 1'b1;
                req_next   = 1'b1;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (sccb.sccb_ack) begin
                    req_next = 1'b0;
                    if (sccb.sccb_err) begin
                        attempt_fail = 1'b1;
                    end else begin
`ifdef CFG_READBACK_EN
                        rd_issued_next = 1'b0;
                        state_next     = VERIFY;
`else
                        state_next     = NEXT;
`endif
                    end
                end
            end
            VERIFY: begin
`ifdef CFG_READBACK_EN
                // First VERIFY cycle keeps req low after the write ack, then raises the read.
                if (!rd_issued_reg) begin
                    req_next       = 1'b1;
                    wr_next        = 1'b0;
                    rd_issued_next = 1'b1;
                end else if (sccb.sccb_ack) begin
                    req_next     = 1'b0;
                    rd_data_next = sccb.sccb_rdata;
                    if (sccb.sccb_err || (sccb.sccb_rdata != wdata_reg)) begin
                        attempt_fail = 1'b1;
                    end else begin
                        state_next = NEXT;
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            NEXT: begin
                attempt_next = '0;
                if (idx_reg == LAST_IDX) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    idx_next      = idx_reg + 8'd1;
                    rom_addr_next = idx_reg + 8'd1;
                    state_next    = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase

        if (attempt_fail) begin
            attempt_next = attempt_reg + 3'd1;
            if (attempt_next == RETRY_LIM) begin
                err_next     = 1'b1;
                err_idx_next = idx_reg;
                state_next   = ERROR;
            end else begin
                state_next = ISSUE;
            end
        end
    end

    assign rom_addr        = rom_addr_reg;
    assign sccb.sccb_req   = req_reg;
    assign sccb.sccb_wr    = wr_reg;
    assign sccb.sccb_addr  = addr_reg;
    assign sccb.sccb_wdata = wdata_reg;
    assign busy            = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
    assign cfg_done        = done_reg;
    assign cfg_err         = err_reg;
    assign err_idx         = err_idx_reg;
    assign rd_data         = rd_data_reg;
endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Scoreboard bench for ov5640_cfg_seq: expected SCCB transactions are queued per scenario
// and compared as the sequencer issues them; the bench acts as ROM and SCCB engine.
module tb_ov5640_cfg_seq;
    localparam int PWR_DLY = 10;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data = '0;
    logic        busy, cfg_done, cfg_err;
    logic [7:0]  err_idx, rd_data;

    ov5640_cfg_seq_if bus();

    ov5640_cfg_seq #(.REG_NUM(8'd3), .PWR_DLY(PWR_DLY), .RETRY_MAX(3)) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sccb     (bus),
        .busy     (busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .err_idx  (err_idx),
        .rd_data  (rd_data)
    );

    always #5 sysclk = ~sysclk;

    logic [23:0] rom [0:255];
    always @(posedge sysclk) rom_data <= rom[rom_addr];

    typedef struct {
        logic        wr;
        logic [7:0]  idx;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        err;
        logic [7:0]  rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t e, got;
    int   checks = 0;
    int   failures = 0;
    int   n, lat;
    logic ok, stable, req_after;

    task automatic push_txn(input logic wr, input logic [7:0] idx, input logic nack, input logic [7:0] rdata);
        txn_t t;
        t.wr = wr; t.idx = idx; t.addr = rom[idx][23:8]; t.wdata = rom[idx][7:0];
        t.err = nack; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    // A successful entry: one write, plus a matching readback when verification is built in.
    task automatic push_ok(input logic [7:0] idx);
        push_txn(1'b1, idx, 1'b0, 8'h00);
`ifdef CFG_READBACK_EN
        push_txn(1'b0, idx, 1'b0, rom[idx][7:0]);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
    endtask

    task automatic wait_req(output txn_t g, output int cycles, output logic found);
        found = 1'b0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            cycles++;
            if (bus.sccb_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        g.wr = bus.sccb_wr; g.idx = rom_addr; g.addr = bus.sccb_addr; g.wdata = bus.sccb_wdata;
        g.err = 1'b0; g.rdata = 8'h00;
    endtask

    // Holds the request for 5 cycles while watching it stay stable, then pulses ack.
    task automatic respond(input logic nack, input logic [7:0] rdata, output logic stab, output logic req_post);
        logic        s_wr;
        logic [15:0] s_addr;
        logic [7:0]  s_wdata;
        s_wr = bus.sccb_wr; s_addr = bus.sccb_addr; s_wdata = bus.sccb_wdata;
        stab = 1'b1;
        repeat (4) begin
            @(negedge sysclk);
            if (bus.sccb_req !== 1'b1 || bus.sccb_wr !== s_wr || bus.sccb_addr !== s_addr || bus.sccb_wdata !== s_wdata)
                stab = 1'b0;
        end
        bus.sccb_ack = 1'b1; bus.sccb_err = nack; bus.sccb_rdata = rdata;
        @(negedge sysclk);
        bus.sccb_ack = 1'b0; bus.sccb_err = 1'b0; bus.sccb_rdata = 8'h00;
        req_post = bus.sccb_req;
    endtask

    task automatic run_txn(input txn_t x, output txn_t g, output logic found, output int cycles,
                           output logic stab, output logic req_post);
        stab = 1'b0;
        req_post = 1'b1;
        wait_req(g, cycles, found);
        if (found) respond(x.err, x.rdata, stab, req_post);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);
        checks++;
        if ({bus.sccb_req, bus.sccb_wr, bus.sccb_addr, bus.sccb_wdata, rom_addr, busy, cfg_done, cfg_err, err_idx, rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_state: got req=%b wr=%b addr=%h wdata=%h rom_addr=%h busy=%b done=%b err=%b err_idx=%h rd=%h, required all zero",
                     bus.sccb_req, bus.sccb_wr, bus.sccb_addr, bus.sccb_wdata, rom_addr, busy, cfg_done, cfg_err, err_idx, rd_data);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_rd;
        push_ok(8'd0); push_ok(8'd1); push_ok(8'd2);
        pulse_start();
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            run_txn(e, got, ok, lat, stable, req_after);
            checks++;
            if (ok !== 1'b1) begin
                failures++; $display("FAIL basic_timeout: no sccb_req for txn %0d", n);
                exp_q.delete(); break;
            end
            if (n == 0) begin
                checks++;
                // start edge, then PWR_DLY wait cycles, FETCH and ISSUE
                if (lat != PWR_DLY + 2) begin
                    failures++; $display("FAIL basic_first_req_latency: got %0d required %0d", lat, PWR_DLY + 2);
                end
            end
            checks++;
            if ({got.wr, got.idx, got.addr, got.wdata} !== {e.wr, e.idx, e.addr, e.wdata}) begin
                failures++;
                $display("FAIL basic_txn%0d: got wr=%b idx=%h addr=%h data=%h required wr=%b idx=%h addr=%h data=%h",
                         n, got.wr, got.idx, got.addr, got.wdata, e.wr, e.idx, e.addr, e.wdata);
            end
            checks++;
            if ({stable, req_after} !== 2'b10) begin
                failures++; $display("FAIL basic_handshake%0d: got stable=%b req_after_ack=%b required 1/0", n, stable, req_after);
            end
            n++;
        end
        repeat (3) @(negedge sysclk);
`ifdef CFG_READBACK_EN
        exp_rd = rom[2][7:0];
`else
        exp_rd = 8'h00;
`endif
        checks++;
        if ({cfg_done, cfg_err, busy, bus.sccb_req, rd_data} !== {4'b1000, exp_rd}) begin
            failures++;
            $display("FAIL basic_end: got done=%b err=%b busy=%b req=%b rd=%h required done=1 err=0 busy=0 req=0 rd=%h",
                     cfg_done, cfg_err, busy, bus.sccb_req, rd_data, exp_rd);
        end
    endtask

    task automatic test_start_while_busy();
        push_ok(8'd0); push_ok(8'd1); push_ok(8'd2);
        pulse_start();
        repeat (3) @(negedge sysclk);
        pulse_start();
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            run_txn(e, got, ok, lat, stable, req_after);
            checks++;
            if (ok !== 1'b1) begin
                failures++; $display("FAIL busy_timeout: no sccb_req for txn %0d", n);
                exp_q.delete(); break;
            end
            checks++;
            if ({got.wr, got.idx, got.addr, got.wdata} !== {e.wr, e.idx, e.addr, e.wdata}) begin
                failures++;
                $display("FAIL busy_txn%0d: got wr=%b idx=%h addr=%h required wr=%b idx=%h addr=%h",
                         n, got.wr, got.idx, got.addr, e.wr, e.idx, e.addr);
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++; $display("FAIL busy_level%0d: got busy=%b required 1", n, busy);
            end
            pulse_start();
            n++;
        end
        repeat (3) @(negedge sysclk);
        checks++;
        if ({cfg_done, cfg_err, busy, bus.sccb_req} !== 4'b1000) begin
            failures++;
            $display("FAIL busy_end: got done=%b err=%b busy=%b req=%b required 1 0 0 0", cfg_done, cfg_err, busy, bus.sccb_req);
        end
    endtask

    task automatic test_retry();
        push_ok(8'd0);
        push_txn(1'b1, 8'd1, 1'b1, 8'h00);
        push_txn(1'b1, 8'd1, 1'b1, 8'h00);
        push_ok(8'd1); push_ok(8'd2);
        pulse_start();
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            run_txn(e, got, ok, lat, stable, req_after);
            checks++;
            if (ok !== 1'b1) begin
                failures++; $display("FAIL retry_timeout: no sccb_req for txn %0d", n);
                exp_q.delete(); break;
            end
            checks++;
            if ({got.wr, got.idx, got.addr, got.wdata, stable, req_after} !== {e.wr, e.idx, e.addr, e.wdata, 2'b10}) begin
                failures++;
                $display("FAIL retry_txn%0d: got wr=%b idx=%h addr=%h stable=%b req_after=%b required wr=%b idx=%h addr=%h stable=1 req_after=0",
                         n, got.wr, got.idx, got.addr, stable, req_after, e.wr, e.idx, e.addr);
            end
            n++;
        end
        repeat (3) @(negedge sysclk);
        checks++;
        if ({cfg_done, cfg_err, busy} !== 3'b100) begin
            failures++; $display("FAIL retry_end: got done=%b err=%b busy=%b required 1 0 0", cfg_done, cfg_err, busy);
        end
    endtask

`ifdef CFG_READBACK_EN
    task automatic test_readback();
        push_txn(1'b1, 8'd0, 1'b0, 8'h00);
        push_txn(1'b0, 8'd0, 1'b0, 8'h02);
        push_txn(1'b1, 8'd0, 1'b0, 8'h00);
        push_txn(1'b0, 8'd0, 1'b0, 8'h42);
        push_ok(8'd1); push_ok(8'd2);
        pulse_start();
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            run_txn(e, got, ok, lat, stable, req_after);
            checks++;
            if (ok !== 1'b1) begin
                failures++; $display("FAIL readback_timeout: no sccb_req for txn %0d", n);
                exp_q.delete(); break;
            end
            checks++;
            if ({got.wr, got.idx, got.addr, stable, req_after} !== {e.wr, e.idx, e.addr, 2'b10}) begin
                failures++;
                $display("FAIL readback_txn%0d: got wr=%b idx=%h addr=%h stable=%b req_after=%b required wr=%b idx=%h addr=%h",
                         n, got.wr, got.idx, got.addr, stable, req_after, e.wr, e.idx, e.addr);
            end
            if (n == 1 || n == 3) begin
                checks++;
                if (rd_data !== e.rdata) begin
                    failures++; $display("FAIL readback_rd_data%0d: got %h required %h", n, rd_data, e.rdata);
                end
            end
            n++;
        end
        repeat (3) @(negedge sysclk);
        checks++;
        if ({cfg_done, cfg_err, busy} !== 3'b100) begin
            failures++; $display("FAIL readback_end: got done=%b err=%b busy=%b required 1 0 0", cfg_done, cfg_err, busy);
        end
    endtask
`endif

    task automatic test_abort();
        push_ok(8'd0); push_ok(8'd1);
        repeat (3) push_txn(1'b1, 8'd2, 1'b1, 8'h00);
        pulse_start();
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            run_txn(e, got, ok, lat, stable, req_after);
            checks++;
            if (ok !== 1'b1) begin
                failures++; $display("FAIL abort_timeout: no sccb_req for txn %0d", n);
                exp_q.delete(); break;
            end
            checks++;
            if ({got.wr, got.idx, got.addr} !== {e.wr, e.idx, e.addr}) begin
                failures++;
                $display("FAIL abort_txn%0d: got wr=%b idx=%h addr=%h required wr=%b idx=%h addr=%h",
                         n, got.wr, got.idx, got.addr, e.wr, e.idx, e.addr);
            end
            n++;
        end
        repeat (2) @(negedge sysclk);
        checks++;
        if ({cfg_err, err_idx, cfg_done, bus.sccb_req, busy} !== {1'b1, 8'd2, 3'b000}) begin
            failures++;
            $display("FAIL abort_state: got err=%b err_idx=%h done=%b req=%b busy=%b required 1 02 0 0 0",
                     cfg_err, err_idx, cfg_done, bus.sccb_req, busy);
        end
        pulse_start();
        checks++;
        if ({cfg_err, err_idx, busy} !== {1'b0, 8'd0, 1'b1}) begin
            failures++; $display("FAIL abort_restart_clear: got err=%b err_idx=%h busy=%b required 0 00 1", cfg_err, err_idx, busy);
        end
        wait_req(got, lat, ok);
        checks++;
        if ({ok, got.idx, got.wr} !== {1'b1, 8'd0, 1'b1} || lat != PWR_DLY + 2) begin
            failures++;
            $display("FAIL abort_restart_first: got found=%b idx=%h wr=%b latency=%0d required 1 00 1 %0d",
                     ok, got.idx, got.wr, lat, PWR_DLY + 2);
        end
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_req(got, lat, ok);
            if (!ok || got.idx == 8'd1) break;
            respond(1'b0, got.wdata, stable, req_after);
        end
        checks++;
        if ({ok, got.idx, bus.sccb_req} !== {1'b1, 8'd1, 1'b1}) begin
            failures++; $display("FAIL rstmid_setup: got found=%b idx=%h req=%b required 1 01 1", ok, got.idx, bus.sccb_req);
        end
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        checks++;
        if ({bus.sccb_req, bus.sccb_wr, bus.sccb_addr, bus.sccb_wdata, rom_addr, busy, cfg_done, cfg_err, err_idx, rd_data} !== '0) begin
            failures++;
            $display("FAIL rstmid_state: got req=%b wr=%b addr=%h wdata=%h rom_addr=%h busy=%b done=%b err=%b, required all zero",
                     bus.sccb_req, bus.sccb_wr, bus.sccb_addr, bus.sccb_wdata, rom_addr, busy, cfg_done, cfg_err);
        end
        bus.sccb_ack = 1'b1; bus.sccb_err = 1'b1;
        @(negedge sysclk);
        bus.sccb_ack = 1'b0; bus.sccb_err = 1'b0;
        repeat (3) @(negedge sysclk);
        checks++;
        if ({bus.sccb_req, busy, cfg_done, cfg_err, err_idx} !== '0) begin
            failures++;
            $display("FAIL rstmid_stale_ack: got req=%b busy=%b done=%b err=%b err_idx=%h required all zero",
                     bus.sccb_req, busy, cfg_done, cfg_err, err_idx);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
        rom[0] = {16'h3008, 8'h42};
        rom[1] = {16'h3103, 8'h11};
        rom[2] = {16'h4300, 8'h6F};
        bus.sccb_ack = 1'b0; bus.sccb_err = 1'b0; bus.sccb_rdata = 8'h00;
        test_reset();
        test_basic();
        test_start_while_busy();
        test_retry();
`ifdef CFG_READBACK_EN
        test_readback();
`endif
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
